// File: rtl/verin_pkg.sv
// Shared types and status-word layout for the rudder-jack angle sensor
// acquisition block (MCP3201 front-end).
package verin_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        UPDATE,
        CS_HOLD
    } state_t;

    localparam int unsigned SAMPLE_LSB  = 0;
    localparam int unsigned COUNT_LSB   = 16;
    localparam int unsigned NULLERR_BIT = 30;
    localparam int unsigned EN_BIT      = 31;

    // MCP3201 frame: 2 sample-phase clocks, 1 null bit, then B11..B0
    localparam int unsigned N_SCLK    = 15;
    localparam int unsigned NULL_EDGE = 3;

    function automatic logic [31:0] pack_status(
        input logic        en,
        input logic        nullerr,
        input logic [7:0]  count,
        input logic [11:0] sample
    );
        logic [31:0] w;
        w                    = '0;
        w[SAMPLE_LSB +: 12]  = sample;
        w[COUNT_LSB +: 8]    = count;
        w[NULLERR_BIT]       = nullerr;
        w[EN_BIT]            = en;
        return w;
    endfunction

endpackage

// File: rtl/verin_sclk_gen.sv
// SCLK half-period divider for the MCP3201 interface; runs only while the
// FSM is shifting, otherwise holds sclk low with the divider cleared.
module verin_sclk_gen #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic clk,
    input  logic reset_n,
    input  logic active,
    output logic sclk,
    output logic rise,
    output logic fall
);

    logic [7:0] half_cnt;
    logic       half_tc;

    assign half_tc = active && (half_cnt == 8'(CLK_DIV - 1));
    // Strobes mark the clk cycle whose closing edge toggles sclk
    assign rise    = half_tc && !sclk;
    assign fall    = half_tc && sclk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            half_cnt <= '0;
            sclk     <= 1'b0;
        end else if (!active) begin
            half_cnt <= '0;
            sclk     <= 1'b0;
        end else if (half_tc) begin
            half_cnt <= '0;
            sclk     <= ~sclk;
        end else begin
            half_cnt <= half_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/verin_adc_acq.sv
// MCP3201 acquisition front-end: periodic or one-shot conversions assembled
// into a 32-bit status word that changes atomically for the PIO.
module verin_adc_acq #(
    parameter int unsigned CLK_DIV     = 25,
    parameter int unsigned CONV_PERIOD = 50000,
    parameter int unsigned CS_HIGH_MIN = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        start,
    input  logic        adc_dout,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic        busy,
    output logic [31:0] data_out
);

    import verin_pkg::*;

    localparam int unsigned PW = (CONV_PERIOD > 1) ? $clog2(CONV_PERIOD) : 1;

    state_t      state;
    logic [PW-1:0] period_cnt;
    logic        period_tc;
    logic [1:0]  dout_sync;
    logic [7:0]  timer;
    logic [3:0]  edge_cnt;
    logic [11:0] shift_reg;
    logic        null_bit;
    logic        en_latched;
    logic [7:0]  conv_count;
    logic        shift_active;
    logic        sclk_rise;
    logic        sclk_fall;

    assign period_tc    = enable && (period_cnt == PW'(CONV_PERIOD - 1));
    assign shift_active = (state == SHIFT);

    verin_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_gen (
        .clk    (clk),
        .reset_n(reset_n),
        .active (shift_active),
        .sclk   (adc_sclk),
        .rise   (sclk_rise),
        .fall   (sclk_fall)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_cnt <= '0;
        end else if (!enable || period_tc) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_sync <= '0;
        end else begin
            dout_sync <= {dout_sync[0], adc_dout};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            adc_cs_n   <= 1'b1;
            busy       <= 1'b0;
            timer      <= '0;
            edge_cnt   <= '0;
            shift_reg  <= '0;
            null_bit   <= 1'b0;
            en_latched <= 1'b0;
            conv_count <= '0;
            data_out   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (period_tc || start) begin
                        state      <= SETUP;
                        adc_cs_n   <= 1'b0;
                        busy       <= 1'b1;
                        timer      <= '0;
                        edge_cnt   <= '0;
                        en_latched <= enable;
                    end
                end
                SETUP: begin
                    if (timer == 8'(CLK_DIV - 1)) begin
                        state <= SHIFT;
                        timer <= '0;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                SHIFT: begin
                    // edge_cnt holds the number of rising edges already seen
                    if (sclk_rise) begin
                        edge_cnt <= edge_cnt + 4'd1;
                        if (edge_cnt == 4'(NULL_EDGE - 1)) begin
                            null_bit <= dout_sync[1];
                        end else if (edge_cnt >= 4'(NULL_EDGE)) begin
                            shift_reg <= {shift_reg[10:0], dout_sync[1]};
                        end
                    end
                    if (sclk_fall && edge_cnt == 4'(N_SCLK)) begin
                        state    <= UPDATE;
                        adc_cs_n <= 1'b1;
                    end
                end
                UPDATE: begin
                    conv_count <= conv_count + 8'd1;
                    data_out   <= pack_status(en_latched, null_bit,
                                              conv_count + 8'd1, shift_reg);
                    state      <= CS_HOLD;
                    timer      <= '0;
                end
                CS_HOLD: begin
                    if (timer == 8'(CS_HIGH_MIN - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    adc_cs_n <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_verin_adc_acq.sv
// Self-checking bench for verin_adc_acq: MCP3201 behavioural model, vector
// table, multi-cycle corner sequences and a randomized 256-frame run.
`timescale 1ns/1ps
module tb_verin_adc_acq;

    localparam int unsigned CLK_DIV     = 4;
    localparam int unsigned CONV_PERIOD = 1000;
    localparam int unsigned CS_HIGH_MIN = 8;
    localparam int unsigned LATENCY     = 1 + CLK_DIV + 30 * CLK_DIV + 1;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        enable   = 1'b0;
    logic        start    = 1'b0;
    logic        adc_dout = 1'b0;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic        busy;
    logic [31:0] data_out;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    verin_adc_acq #(
        .CLK_DIV    (CLK_DIV),
        .CONV_PERIOD(CONV_PERIOD),
        .CS_HIGH_MIN(CS_HIGH_MIN)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .start   (start),
        .adc_dout(adc_dout),
        .adc_cs_n(adc_cs_n),
        .adc_sclk(adc_sclk),
        .busy    (busy),
        .data_out(data_out)
    );

    always #5 clk = ~clk;

    // ADC model and bus monitor
    logic        adc_null   = 1'b0;
    logic [11:0] adc_sample = '0;
    int unsigned cyc         = 0;
    int unsigned frame_rises = 0;
    int unsigned total_rises = 0;
    int unsigned frame_starts[$];
    logic        prev_sclk = 1'b0;
    logic        prev_cs   = 1'b1;

    function automatic logic adc_bit(input int unsigned n, input logic nb,
                                     input logic [11:0] s);
        if (n == 3) return nb;
        if (n >= 4 && n <= 15) return s[15 - n];
        return 1'($urandom);
    endfunction

    function automatic logic [31:0] expect_word(input logic en, input logic nb,
                                                input int unsigned frames_done,
                                                input logic [11:0] s);
        logic [7:0] c;
        c = 8'(frames_done % 256);
        return {en, nb, 6'b0, c, 4'b0, s};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_sclk <= adc_sclk;
        prev_cs   <= adc_cs_n;
        if (prev_cs && !adc_cs_n) begin
            frame_starts.push_back(cyc);
            frame_rises <= 0;
            adc_dout    <= adc_bit(1, adc_null, adc_sample);
        end else if (!prev_sclk && adc_sclk) begin
            total_rises <= total_rises + 1;
            frame_rises <= frame_rises + 1;
        end else if (prev_sclk && !adc_sclk) begin
            adc_dout <= adc_bit(frame_rises + 1, adc_null, adc_sample);
        end
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string tag);
        int unsigned k;
        k = 0;
        while (busy && k < 4 * LATENCY) begin
            tick(1);
            k++;
        end
        check({tag, "_idle"}, {31'b0, busy}, 32'h0);
    endtask

    task automatic run_frame(input logic nb, input logic [11:0] s,
                             input logic [31:0] exp, input logic extra_start,
                             input string tag);
        logic [31:0] prev;
        int unsigned lat, rises0, f0;
        adc_null   = nb;
        adc_sample = s;
        prev   = data_out;
        rises0 = total_rises;
        f0     = frame_starts.size();
        start  = 1'b1;
        lat    = 0;
        do begin
            tick(1);
            lat++;
            start = 1'b0;
            if (extra_start && lat == 8 * CLK_DIV) start = 1'b1;
        end while (data_out == prev && lat < 4 * LATENCY);
        start = 1'b0;
        check({tag, "_data"}, data_out, exp);
        check({tag, "_latency"}, 32'(lat), 32'(LATENCY));
        wait_idle(tag);
        tick(4);
        check({tag, "_sclk_rises"}, 32'(total_rises - rises0), 32'd15);
        check({tag, "_frames"}, 32'(frame_starts.size() - f0), 32'd1);
        check({tag, "_cs_n"}, {31'b0, adc_cs_n}, 32'h1);
    endtask

    typedef struct {
        logic        nb;
        logic [11:0] s;
        logic        extra;
        logic [31:0] exp;
    } vec_t;

    initial begin
        vec_t        vecs[6];
        int unsigned f0, c0, k;
        logic        nb;
        logic [11:0] s;

        vecs[0] = '{1'b0, 12'hA5C, 1'b0, 32'h0001_0A5C};
        vecs[1] = '{1'b1, 12'hFFF, 1'b0, 32'h4002_0FFF};
        vecs[2] = '{1'b0, 12'h123, 1'b0, 32'h0003_0123};
        vecs[3] = '{1'b0, 12'h000, 1'b1, 32'h0004_0000};
        vecs[4] = '{1'b1, 12'h001, 1'b0, 32'h4005_0001};
        vecs[5] = '{1'b0, 12'h800, 1'b1, 32'h0006_0800};

        tick(3);
        check("rst_cs_n", {31'b0, adc_cs_n}, 32'h1);
        check("rst_sclk", {31'b0, adc_sclk}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_data", data_out, 32'h0);
        reset_n = 1'b1;
        tick(2);

        for (int i = 0; i < 6; i++)
            run_frame(vecs[i].nb, vecs[i].s, vecs[i].exp, vecs[i].extra,
                      $sformatf("vec%0d", i));

        // Reset at the 7th SCLK rising edge of a frame
        f0 = frame_starts.size();
        adc_sample = 12'h3C3;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        k = 0;
        while ((frame_starts.size() == f0 || frame_rises < 7) && k < 4 * LATENCY) begin
            @(negedge clk);
            k++;
        end
        check("midrst_edge7", 32'(frame_rises), 32'd7);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_cs_n", {31'b0, adc_cs_n}, 32'h1);
        check("midrst_sclk", {31'b0, adc_sclk}, 32'h0);
        check("midrst_busy", {31'b0, busy}, 32'h0);
        check("midrst_data", data_out, 32'h0);
        tick(2);
        reset_n = 1'b1;
        f0 = frame_starts.size();
        tick(3 * LATENCY);
        check("midrst_no_update", data_out, 32'h0);
        check("midrst_no_frame", 32'(frame_starts.size() - f0), 32'd0);

        // Periodic mode for 3.2 periods
        adc_null   = 1'b0;
        adc_sample = 12'h123;
        f0 = frame_starts.size();
        enable = 1'b1;
        c0 = cyc;
        tick(CONV_PERIOD * 32 / 10);
        enable = 1'b0;
        wait_idle("per");
        check("per_frames", 32'(frame_starts.size() - f0), 32'd3);
        if (frame_starts.size() >= f0 + 3) begin
            check("per_first", 32'(frame_starts[f0] - c0), 32'(CONV_PERIOD));
            check("per_gap1", 32'(frame_starts[f0 + 1] - frame_starts[f0]), 32'(CONV_PERIOD));
            check("per_gap2", 32'(frame_starts[f0 + 2] - frame_starts[f0 + 1]), 32'(CONV_PERIOD));
        end
        check("per_data", data_out, 32'h8003_0123);

        // enable falls mid-frame: frame completes, no further frames
        f0 = frame_starts.size();
        enable = 1'b1;
        k = 0;
        while (frame_starts.size() == f0 && k < 2 * CONV_PERIOD) begin
            tick(1);
            k++;
        end
        tick(10 * CLK_DIV);
        enable = 1'b0;
        wait_idle("enfall");
        check("enfall_data", data_out, 32'h8004_0123);
        f0 = frame_starts.size();
        tick(2 * CONV_PERIOD);
        check("enfall_no_frame", 32'(frame_starts.size() - f0), 32'd0);

        // start coincident with period terminal count
        adc_sample = 12'h5A5;
        f0 = frame_starts.size();
        enable = 1'b1;
        c0 = cyc;
        tick(CONV_PERIOD - 1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(CONV_PERIOD - 100);
        enable = 1'b0;
        wait_idle("coinc");
        check("coinc_frames", 32'(frame_starts.size() - f0), 32'd1);
        if (frame_starts.size() > f0)
            check("coinc_start_cycle", 32'(frame_starts[f0] - c0), 32'(CONV_PERIOD));
        check("coinc_data", data_out, 32'h8005_05A5);

        // 256 randomized one-shot frames from reset, covering count wrap
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        for (int unsigned i = 0; i < 256; i++) begin
            nb = 1'($urandom);
            s  = 12'($urandom);
            run_frame(nb, s, expect_word(1'b0, nb, i + 1, s),
                      1'($urandom_range(0, 3) == 0), $sformatf("rnd%0d", i));
            if (i == 254) check("wrap_ff", {24'b0, data_out[23:16]}, 32'hFF);
            if (i == 255) check("wrap_00", {24'b0, data_out[23:16]}, 32'h00);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/verin_adc_acq.md
Name: verin_adc_acq

Overview:
- Acquisition front-end for the rudder-jack angle sensor.
- Drives an MCP3201 12-bit SPI ADC (CS_n/SCLK/DOUT) and assembles each conversion into a coherent 32-bit status word.
- The status word feeds the 32-bit input PIO read by the Nios II, so the word must change atomically in a single clk cycle.
- Conversions run periodically while enabled, or on a one-shot request.

Parameters:
- CLK_DIV, 25, clk cycles per SCLK half-period (50 MHz clk gives 1 MHz SCLK); legal range 2..255.
- CONV_PERIOD, 50000, clk cycles between conversion starts in periodic mode (1 kHz); must be at least the length of one full frame.
- CS_HIGH_MIN, 32, minimum clk cycles CS_n is held high between frames.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  periodic conversion enable
- start  in  1  one-cycle single-conversion request; accepted only in IDLE
- adc_dout  in  1  ADC serial data; synchronised by 2 flops inside the block
- adc_cs_n  out  1  ADC chip select, active low
- adc_sclk  out  1  ADC serial clock; idles low
- busy  out  1  high from frame start through the end of CS_HOLD
- data_out  out  32  status word to the PIO in_port

Behaviour:
- Reset: clk is clk; reset_n is asynchronous, active-low.
  - Outputs while reset_n is low: adc_cs_n=1, adc_sclk=0, busy=0, data_out=0.
  - All timers, shift register and counters clear.
  - Reset asserted mid-frame aborts the frame immediately; data_out is not updated.
- data_out format:
  - [11:0] last sample, MSB first as received
  - [15:12] zero
  - [23:16] conversion count mod 256; increments by 1 per completed frame, 255 wraps to 0
  - [29:24] zero
  - [30] null-bit error: the null bit of the last frame read as 1
  - [31] enable as sampled at the last frame start
- Period timer:
  - Free-runs 0..CONV_PERIOD-1 while enable=1; clears to 0 while enable=0.
  - Terminal count while enable=1 requests a frame.
- Frame start: a request occurs when the period timer hits terminal count or start=1, and the FSM is in IDLE.
  - Requests arriving outside IDLE are dropped, not queued.
  - start and terminal count in the same cycle produce one frame.
- FSM states:
  - IDLE: cs_n=1, sclk=0. On request go to SETUP.
  - SETUP: cs_n=0 for CLK_DIV cycles (tSUCS), then go to SHIFT.
  - SHIFT: 15 SCLK periods. Each period is CLK_DIV cycles low, then CLK_DIV cycles high.
    - Sample the synchronised dout on the clk cycle where sclk rises; the 2-flop sync delay is absorbed by CLK_DIV ≥ 2.
    - Rising edges 1–2: sample phase, data ignored.
    - Rising edge 3: null bit.
    - Rising edges 4..15: B11..B0, shifted in MSB first.
    - After the 15th high phase, sclk returns low and the FSM goes to UPDATE.
  - UPDATE: one cycle. data_out is written in full (sample, count+1, null error, enable); cs_n=1. Then go to CS_HOLD.
  - CS_HOLD: cs_n=1 for CS_HIGH_MIN cycles, then return to IDLE.
- Latency: start accepted to data_out update = 1 + CLK_DIV + 30·CLK_DIV + 1 cycles. This is 777 cycles at defaults.
- enable falling mid-frame: the current frame completes and the period timer clears.
- Widths:
  - Half-period counter is 8 bits.
  - SCLK edge counter is 4 bits (0..15).
  - Period counter is ceil(log2(CONV_PERIOD)) bits.

Decomposition:
- Package verin_pkg holds:
  - FSM state enumeration (IDLE, SETUP, SHIFT, UPDATE, CS_HOLD)
  - data_out field positions: SAMPLE_LSB=0, COUNT_LSB=16, NULLERR_BIT=30, EN_BIT=31
  - MCP3201 frame constant N_SCLK=15
- One natural sub-module, verin_sclk_gen:
  - Half-period divider producing sclk plus one-cycle rise/fall strobes.
  - Gated by the FSM's shift-active signal.

Test Plan:
- Reset mid-SHIFT (reset_n low at SCLK edge 7) -> cs_n=1, sclk=0, data_out=0 immediately; no update after release until a new request.
- enable=0; start pulse; ADC model returns null=0, sample 0xA5C -> after 777 cycles data_out=0x00010A5C, busy low after CS_HOLD; exactly 15 sclk rising edges observed.
- enable=1 for 3.2 ms at defaults; model returns 0x123 -> exactly 3 frames, frames start 50000 cycles apart; final data_out=0x80030123.
- Model drives null bit=1, sample 0xFFF -> data_out[30]=1, [11:0]=0xFFF; next frame with null=0 clears bit 30.
- Force 256 conversions -> count field goes 0xFF to 0x00; a start pulse during SHIFT produces no extra frame.
- start and period terminal count in the same cycle -> a single frame only; count increments by 1.
